// File: rtl/csa_resolver.sv
// Chunked carry-propagate adder that turns a carry-save sum/carry pair into a binary result.
// Resolves ChunkWidth bits per cycle with a registered inter-chunk carry.
module csa_resolver #(
    parameter int DataWidth  = 128,
    parameter int ChunkWidth = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DataWidth-1:0] Sum,
    input  logic [DataWidth-1:0] Carry,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] Result,
    output logic                 CarryOut
);

    localparam int NumChunks = DataWidth / ChunkWidth;
    localparam int KW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [KW-1:0] LastK = KW'(NumChunks - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [KW-1:0]          k_r;
    logic                   cy_r;
    logic [DataWidth-1:0]   sum_r;
    logic [DataWidth-1:0]   carry_r;
    logic [DataWidth-1:0]   result_r;
    logic                   carry_out_r;

    logic [ChunkWidth-1:0]  chunk_a_s;
    logic [ChunkWidth-1:0]  chunk_b_s;
    logic [ChunkWidth:0]    chunk_sum_s;

    // Add the current chunk of both operands plus the carry rippled from the previous chunk.
    always_comb begin
        chunk_a_s   = sum_r[k_r*ChunkWidth +: ChunkWidth];
        chunk_b_s   = carry_r[k_r*ChunkWidth +: ChunkWidth];
        chunk_sum_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{ChunkWidth{1'b0}}, cy_r};
    end

    // Control FSM with operand capture and chunk-by-chunk result write-back.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r     <= ST_IDLE;
            k_r         <= {KW{1'b0}};
            cy_r        <= 1'b0;
            sum_r       <= {DataWidth{1'b0}};
            carry_r     <= {DataWidth{1'b0}};
            result_r    <= {DataWidth{1'b0}};
            carry_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (InValid) begin
                        sum_r   <= Sum;
                        carry_r <= Carry;
                        k_r     <= {KW{1'b0}};
                        cy_r    <= 1'b0;
                        state_r <= ST_ADD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    result_r[k_r*ChunkWidth +: ChunkWidth] <= chunk_sum_s[ChunkWidth-1:0];
                    cy_r <= chunk_sum_s[ChunkWidth];
                    if (k_r == LastK) begin
                        carry_out_r <= chunk_sum_s[ChunkWidth];
                        state_r     <= ST_DONE;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // InReady drops combinationally with Rst so nothing is offered while reset is held.
    assign InReady  = (state_r == ST_IDLE) && Rst;
    assign OutValid = (state_r == ST_DONE);
    assign Result   = result_r;
    assign CarryOut = carry_out_r;

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomized checks for csa_resolver at the default 128/32 configuration.
module tb_csa_resolver;

    logic         Clk;
    logic         Rst;
    logic         InValid;
    logic         InReady;
    logic [127:0] Sum;
    logic [127:0] Carry;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] Result;
    logic         CarryOut;

    int errors = 0;
    int checks = 0;

    csa_resolver #(.DataWidth(128), .ChunkWidth(32)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .Sum      (Sum),
        .Carry    (Carry),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .CarryOut (CarryOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Accept one pair, wait for OutValid, capture outputs and latency, then consume.
    task automatic run_op(input logic [127:0] s, input logic [127:0] c,
                          output logic [127:0] res, output logic cout, output int lat);
        int w;
        w = 0;
        while (!InReady && w < 20) begin
            tick();
            w++;
        end
        Sum = s;
        Carry = c;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 20) begin
            tick();
            lat++;
        end
        res = Result;
        cout = CarryOut;
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        tick();
        tick();
        checks++;
        if (OutValid !== 1'b0 || Result !== 128'd0 || CarryOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: OutValid=%b Result=%h CarryOut=%b, want 0/0/0", OutValid, Result, CarryOut);
        end
        checks++;
        if (InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_inready_low: got %b want 0", InReady);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready_release: got %b want 1", InReady);
        end
    endtask

    task automatic test_directed();
        logic [127:0] res;
        logic cout;
        int lat;
        run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, res, cout, lat);
        checks++;
        if (res !== 128'h0000_0000_0000_0000_0000_0001_0000_0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL cross_chunk: got %h/%b want 100000000/0", res, cout);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL latency: got %0d want 4", lat);
        end
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle_valid: OutValid=%b want 0", OutValid);
        end
        run_op({128{1'b1}}, 128'd1, res, cout, lat);
        checks++;
        if (res !== 128'd0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL full_ripple: got %h/%b want 0/1", res, cout);
        end
        run_op(128'hB, 128'hA, res, cout, lat);
        checks++;
        if (res !== 128'h15 || cout !== 1'b0) begin
            errors++;
            $display("FAIL compressor_5_7_9: got %h/%b want 15/0", res, cout);
        end
    endtask

    task automatic test_random();
        logic [127:0] a, b, c, s, cy, res, want;
        logic [128:0] wide;
        logic cout;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = rand128();
            b = rand128();
            c = rand128();
            s = a ^ b ^ c;
            cy = ((a & b) | (a & c) | (b & c)) << 1;
            want = a + b + c;
            wide = {1'b0, s} + {1'b0, cy};
            run_op(s, cy, res, cout, lat);
            checks++;
            if (res !== want || cout !== wide[128]) begin
                errors++;
                $display("FAIL random_%0d: got %h/%b want %h/%b", i, res, cout, want, wide[128]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] want;
        want = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321 + 128'h1111_1111_FFFF_FFFF_2222_2222_FFFF_FFFF;
        Sum = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        Carry = 128'h1111_1111_FFFF_FFFF_2222_2222_FFFF_FFFF;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 20) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            InValid = ~InValid;
            Sum = rand128();
            Carry = rand128();
            tick();
            checks++;
            if (OutValid !== 1'b1 || Result !== want || InReady !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d: OutValid=%b InReady=%b Result=%h want 1/0/%h", i, OutValid, InReady, Result, want);
            end
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: OutValid=%b InReady=%b want 0/1", OutValid, InReady);
        end
        tick();
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_accept: InReady=%b OutValid=%b want 1/0", InReady, OutValid);
        end
    endtask

    task automatic test_reset_mid_add();
        logic [127:0] res;
        logic cout;
        int lat;
        Sum = {128{1'b1}};
        Carry = 128'd2;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        tick();
        Rst = 1'b0;
        tick();
        checks++;
        if (OutValid !== 1'b0 || Result !== 128'd0 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_add: OutValid=%b Result=%h InReady=%b want 0/0/0", OutValid, Result, InReady);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_add_ready: got %b want 1", InReady);
        end
        run_op(128'h0000_0001_0000_0000_FFFF_FFFF_0000_0003, 128'h0000_0000_0000_0001_0000_0001_0000_0004, res, cout, lat);
        checks++;
        if (res !== 128'h0000_0001_0000_0002_0000_0000_0000_0007 || cout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: got %h/%b want 00000001000000020000000000000007/0", res, cout);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[2];
        logic [127:0] res_q[2];
        int n_acc, n_res, cyc;
        n_acc = 0;
        n_res = 0;
        cyc = 0;
        Sum = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
        Carry = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
        InValid = 1'b1;
        OutReady = 1'b1;
        while (n_res < 2 && cyc < 40) begin
            if (InValid && InReady && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (OutValid) begin
                res_q[n_res] = Result;
                n_res++;
            end
            tick();
            cyc++;
            if (n_acc == 1) begin
                Sum = 128'h0000_0000_8000_0000_8000_0000_8000_0000;
                Carry = 128'h0000_0000_8000_0000_8000_0000_8000_0000;
            end
            if (n_acc == 2) InValid = 1'b0;
        end
        OutReady = 1'b0;
        checks++;
        if (n_res !== 2 || n_acc !== 2) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepts=%0d want 2/2", n_res, n_acc);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 6) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want 6", acc_cyc[1] - acc_cyc[0]);
            end
            checks++;
            if (res_q[0] !== 128'd0) begin
                errors++;
                $display("FAIL b2b_first: got %h want 0", res_q[0]);
            end
            checks++;
            if (res_q[1] !== 128'h0000_0001_0000_0001_0000_0001_0000_0000) begin
                errors++;
                $display("FAIL b2b_second: got %h want 00000001000000010000000100000000", res_q[1]);
            end
        end
    endtask

    initial begin
        Rst = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b0;
        Sum = 128'd0;
        Carry = 128'd0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
